// File: rtl/fifo_write_ctrl.sv
// Write-side pointer and flag controller for the async FIFO.
// Lives entirely in the write clock domain: synchronises the incoming read
// Gray pointer, drives the RAM write port, exports the write Gray pointer and
// derives full / almost-full / fill level / sticky overflow.
module fifo_write_ctrl #(
    parameter int ADD_WIDTH = 3,
    parameter int AF_MARGIN = 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_en,
    input  logic [ADD_WIDTH:0]   rd_ptr_gry,
    input  logic                 ovf_clr,
    output logic [ADD_WIDTH-1:0] wr_addrs,
    output logic                 mem_wr_en,
    output logic [ADD_WIDTH:0]   wr_ptr_bin_gry,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic [ADD_WIDTH:0]   wr_level,
    output logic                 overflow
);

    localparam int PW    = ADD_WIDTH + 1;
    localparam int DEPTH = 1 << ADD_WIDTH;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] wr_ptr_bin;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] sync1;
    logic [PW-1:0] rd_gry_sync;
    logic [PW-1:0] rd_bin;
    logic          accept;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Two-flop synchroniser for the read Gray pointer.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            sync1       <= '0;
            rd_gry_sync <= '0;
        end else begin
            sync1       <= rd_ptr_gry;
            rd_gry_sync <= sync1;
        end
    end

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    always_comb begin
        fifo_full = (wr_ptr_bin_gry ==
                     {~rd_gry_sync[ADD_WIDTH:ADD_WIDTH-1], rd_gry_sync[ADD_WIDTH-2:0]});
        accept    = wr_en & ~fifo_full;
        mem_wr_en = accept;
        ptr_next  = wr_ptr_bin + 1'b1;
    end

    // Binary and Gray write pointers advance together on an accepted write.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_ptr_bin     <= '0;
            wr_ptr_bin_gry <= '0;
        end else if (accept) begin
            wr_ptr_bin     <= ptr_next;
            wr_ptr_bin_gry <= bin2gray(ptr_next);
        end
    end

    // Sticky overflow; a rejected write in the same cycle beats the clear.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            overflow <= 1'b0;
        end else if (wr_en & fifo_full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Level uses the stale read pointer, so it can only over-report.
    always_comb begin
        rd_bin      = gray2bin(rd_gry_sync);
        wr_level    = wr_ptr_bin - rd_bin;
        almost_full = (wr_level >= AF_LEVEL);
        wr_addrs    = wr_ptr_bin[ADD_WIDTH-1:0];
    end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl with ADD_WIDTH=3, AF_MARGIN=2.
module tb_fifo_write_ctrl;

    logic       wr_clk = 1'b0;
    logic       wr_rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] rd_ptr_gry = 4'd0;
    logic       ovf_clr = 1'b0;
    logic [2:0] wr_addrs;
    logic       mem_wr_en;
    logic [3:0] wr_ptr_bin_gry;
    logic       fifo_full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_gry [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    fifo_write_ctrl #(.ADD_WIDTH(3), .AF_MARGIN(2)) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_en(wr_en), .rd_ptr_gry(rd_ptr_gry),
        .ovf_clr(ovf_clr), .wr_addrs(wr_addrs), .mem_wr_en(mem_wr_en),
        .wr_ptr_bin_gry(wr_ptr_bin_gry), .fifo_full(fifo_full),
        .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; ovf_clr = 1'b0; rd_ptr_gry = 4'd0; wr_rst = 1'b1;
        step();
        wr_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({wr_addrs, wr_ptr_bin_gry, fifo_full, almost_full, wr_level, overflow, mem_wr_en} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0d gry=%b full=%b af=%b lvl=%0d ovf=%b we=%b, want all 0",
                     wr_addrs, wr_ptr_bin_gry, fifo_full, almost_full, wr_level, overflow, mem_wr_en);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            #1;
            n_checks++;
            if (mem_wr_en !== 1'b1 || wr_addrs !== 3'(i)) begin
                n_fail++;
                $display("FAIL fill_write%0d: got we=%b addr=%0d, want we=1 addr=%0d", i, mem_wr_en, wr_addrs, i);
            end
            step();
        end
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (fifo_full !== 1'b1 || wr_level !== 4'd8 || wr_ptr_bin_gry !== 4'b1100) begin
            n_fail++;
            $display("FAIL fill_full: got full=%b lvl=%0d gry=%b, want 1 8 1100", fifo_full, wr_level, wr_ptr_bin_gry);
        end
        wr_en = 1'b1;
        #1;
        n_checks++;
        if (mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_reject_we: got we=%b, want 0", mem_wr_en);
        end
        step();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (overflow !== 1'b1 || wr_ptr_bin_gry !== 4'b1100 || wr_addrs !== 3'd0 || wr_level !== 4'd8) begin
            n_fail++;
            $display("FAIL fill_overflow: got ovf=%b gry=%b addr=%0d lvl=%0d, want 1 1100 0 8",
                     overflow, wr_ptr_bin_gry, wr_addrs, wr_level);
        end
    endtask

    // Continues from the full state left by test_fill.
    task automatic test_release();
        rd_ptr_gry = 4'b0001;
        step();
        n_checks++;
        if (fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL release_edge1: got full=%b, want 1", fifo_full);
        end
        step();
        n_checks++;
        if (fifo_full !== 1'b0 || wr_level !== 4'd7 || wr_addrs !== 3'd0) begin
            n_fail++;
            $display("FAIL release_edge2: got full=%b lvl=%0d addr=%0d, want 0 7 0", fifo_full, wr_level, wr_addrs);
        end
        wr_en = 1'b1;
        #1;
        n_checks++;
        if (mem_wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL release_accept: got we=%b, want 1", mem_wr_en);
        end
        step();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (fifo_full !== 1'b1 || wr_ptr_bin_gry !== 4'b1101 || wr_level !== 4'd8) begin
            n_fail++;
            $display("FAIL release_refull: got full=%b gry=%b lvl=%0d, want 1 1101 8", fifo_full, wr_ptr_bin_gry, wr_level);
        end
    endtask

    // Continues from full with overflow already set.
    task automatic test_overflow_clear();
        ovf_clr = 1'b1;
        step();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear_alone: got ovf=%b, want 0", overflow);
        end
        wr_en = 1'b1;
        step();
        n_checks++;
        if (overflow !== 1'b1 || wr_ptr_bin_gry !== 4'b1101) begin
            n_fail++;
            $display("FAIL ovf_set_priority: got ovf=%b gry=%b, want 1 1101", overflow, wr_ptr_bin_gry);
        end
        wr_en = 1'b0;
        step();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear_next: got ovf=%b, want 0", overflow);
        end
        ovf_clr = 1'b0;
    endtask

    task automatic test_almost_full();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (almost_full !== 1'b0 || wr_level !== 4'd5) begin
            n_fail++;
            $display("FAIL af_level5: got af=%b lvl=%0d, want 0 5", almost_full, wr_level);
        end
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (almost_full !== 1'b1 || wr_level !== 4'd6 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL af_level6: got af=%b lvl=%0d full=%b, want 1 6 0", almost_full, wr_level, fifo_full);
        end
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (almost_full !== 1'b1 || wr_level !== 4'd7 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL af_level7: got af=%b lvl=%0d full=%b, want 1 7 0", almost_full, wr_level, fifo_full);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        prev = 4'b0000;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            rd_ptr_gry = (i == 0) ? 4'b0000 : exp_gry[i-1];
            #1;
            n_checks++;
            if (mem_wr_en !== 1'b1 || wr_addrs !== 3'(i % 8) || fifo_full !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_pre%0d: got we=%b addr=%0d full=%b, want 1 %0d 0", i, mem_wr_en, wr_addrs, fifo_full, i % 8);
            end
            step();
            n_checks++;
            if (wr_ptr_bin_gry !== exp_gry[i] || $countones(wr_ptr_bin_gry ^ prev) != 1) begin
                n_fail++;
                $display("FAIL wrap_gray%0d: got gry=%b prev=%b, want %b", i, wr_ptr_bin_gry, prev, exp_gry[i]);
            end
            prev = exp_gry[i];
        end
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (wr_addrs !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_addr_end: got addr=%0d, want 0", wr_addrs);
        end
    endtask

    task automatic test_sync_reset();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        wr_en = 1'b0;
        #2;
        wr_rst = 1'b1;
        #1;
        n_checks++;
        if (wr_addrs !== 3'd3 || wr_ptr_bin_gry !== 4'b0010 || wr_level !== 4'd3) begin
            n_fail++;
            $display("FAIL rst_no_async_assert: got addr=%0d gry=%b lvl=%0d, want 3 0010 3", wr_addrs, wr_ptr_bin_gry, wr_level);
        end
        wr_en = 1'b1;
        step();
        #2;
        wr_rst = 1'b0;
        #1;
        n_checks++;
        if (wr_addrs !== 3'd0 || wr_ptr_bin_gry !== 4'd0 || wr_level !== 4'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_applied: got addr=%0d gry=%b lvl=%0d ovf=%b, want 0 0000 0 0",
                     wr_addrs, wr_ptr_bin_gry, wr_level, overflow);
        end
        step();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (wr_addrs !== 3'd1 || wr_ptr_bin_gry !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_release_write: got addr=%0d gry=%b, want 1 0001", wr_addrs, wr_ptr_bin_gry);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release();
        test_overflow_clear();
        test_almost_full();
        test_wrap();
        test_sync_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
